// File: rtl/axi_full_rd_burst_engine.sv
// AXI4 read master: splits a (start address, beat count) command into INCR bursts
// bounded by MAX_BURST and 4KB pages, with up to MAX_OUTST bursts in flight.
module axi_full_rd_burst_engine #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 4,
    parameter int ARID_VAL  = 0,
    parameter int MAX_BURST = 16,
    parameter int MAX_OUTST = 4,
    parameter int LEN_W     = 16
) (
    input  logic              AXI_ACLK,
    input  logic              AXI_ARESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_beats,
    output logic              AXI_ARVALID,
    input  logic              AXI_ARREADY,
    output logic [ID_W-1:0]   AXI_ARID,
    output logic [ADDR_W-1:0] AXI_ARADDR,
    output logic [7:0]        AXI_ARLEN,
    output logic [2:0]        AXI_ARSIZE,
    output logic [1:0]        AXI_ARBURST,
    output logic [3:0]        AXI_ARCACHE,
    output logic [2:0]        AXI_ARPROT,
    output logic [3:0]        AXI_ARQOS,
    input  logic              AXI_RVALID,
    output logic              AXI_RREADY,
    input  logic [DATA_W-1:0] AXI_RDATA,
    input  logic [1:0]        AXI_RRESP,
    input  logic              AXI_RLAST,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              err,
    output logic              busy
);
    localparam int BPB = DATA_W / 8;
    localparam int SZ  = $clog2(BPB);
    localparam int OW  = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr;
    logic [LEN_W-1:0]   remaining, total, received;
    logic [OW-1:0]      outst;
    logic [12:0]        page_room;
    logic [31:0]        beats;
    logic               cmd_hs, ar_hs, r_hs, last_burst, last_beat, final_beat;

    assign cmd_ready  = (state == IDLE) && !AXI_ARESET;
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign ar_hs      = AXI_ARVALID && AXI_ARREADY;
    assign r_hs       = AXI_RVALID && out_ready;
    assign busy       = (state != IDLE);
    assign last_beat  = busy && (received == total - LEN_W'(1));
    assign final_beat = r_hs && last_beat;

    // Beats left before the 4KB page ends, in units of bus beats.
    assign page_room = (13'd4096 - {1'b0, addr[11:0]}) >> SZ;

    always_comb begin
        beats = 32'(remaining);
        if (32'(MAX_BURST) < beats) beats = 32'(MAX_BURST);
        if (32'(page_room) < beats) beats = 32'(page_room);
    end

    assign last_burst = (32'(remaining) == beats);

    assign AXI_ARVALID = (state == ISSUE) && (outst < OW'(MAX_OUTST));
    assign AXI_ARADDR  = addr;
    assign AXI_ARLEN   = 8'(beats - 32'd1);
    assign AXI_ARID    = ID_W'(ARID_VAL);
    assign AXI_ARSIZE  = 3'(SZ);
    assign AXI_ARBURST = 2'b01;
    assign AXI_ARCACHE = 4'b0011;
    assign AXI_ARPROT  = 3'b000;
    assign AXI_ARQOS   = 4'b0000;

    assign AXI_RREADY = out_ready;
    assign out_valid  = AXI_RVALID;
    assign out_data   = AXI_RDATA;
    assign out_last   = AXI_RVALID && last_beat;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (cmd_hs && cmd_beats != '0) state_nxt = ISSUE;
            ISSUE: if (ar_hs && last_burst) state_nxt = DRAIN;
            DRAIN: if (final_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_ARESET) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            total     <= '0;
            received  <= '0;
            outst     <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (cmd_hs && cmd_beats == '0) || (state == DRAIN && final_beat);

            if (cmd_hs) begin
                addr      <= (cmd_addr >> SZ) << SZ;
                remaining <= cmd_beats;
                total     <= cmd_beats;
                received  <= '0;
                err       <= 1'b0;
            end else begin
                if (r_hs && busy) begin
                    received <= received + LEN_W'(1);
                    if (AXI_RRESP != 2'b00) err <= 1'b1;
                end
                if (ar_hs) begin
                    addr      <= addr + ADDR_W'(beats << SZ);
                    remaining <= remaining - LEN_W'(beats);
                end
            end

            // A burst issued and another retired in the same cycle cancel out.
            case ({ar_hs, r_hs && AXI_RLAST})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase
        end
    end
endmodule
